// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 codes,
// state encoding, byte-enable and store-lane replication.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        STORE,
        LOAD_ADDR,
        LOAD_DATA,
        RESP
    } lsu_state_e;

    function automatic logic f3_legal(input logic wr, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        unique case (1'b1)
            f3 == F3_B,
            f3 == F3_H,
            f3 == F3_W:  ok = 1'b1;
            f3 == F3_BU,
            f3 == F3_HU: ok = !wr;
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == 2'b01) && off[0]) ||
               ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        unique case (1'b1)
            f3 == F3_B: be = 4'b0001 << off;
            f3 == F3_H: be = 4'b0011 << off;
            f3 == F3_W: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_rep(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        d = wd;
        unique case (1'b1)
            f3 == F3_B: d = {4{wd[7:0]}};
            f3 == F3_H: d = {2{wd[15:0]}};
            default:    d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Moves the addressed byte/half of a memory word down to bit 0 and
// sign- or zero-extends it according to the load funct3.
module load_align_ext
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = word_i >> {offset_i, 3'b000};
        data_o  = 32'h0;
        unique case (1'b1)
            funct3_i == F3_B:  data_o = {{24{shifted[7]}}, shifted[7:0]};
            funct3_i == F3_H:  data_o = {{16{shifted[15]}}, shifted[15:0]};
            funct3_i == F3_W:  data_o = shifted;
            funct3_i == F3_BU: data_o = {24'h0, shifted[7:0]};
            funct3_i == F3_HU: data_o = {16'h0, shifted[15:0]};
            default:           data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, alignment/window checks,
// byte lanes for stores, aligned and extended data for loads.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_ADDR_WIDTH = 18,
    parameter logic [31:0] MEM_BASE       = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [2:0]                req_funct3,
    input  logic [31:0]               req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic                      mem_write,
    output logic [3:0]                mem_byte_en,
    output logic [MEM_ADDR_WIDTH-1:0] mem_write_addr,
    output logic [MEM_ADDR_WIDTH-1:0] mem_read_addr,
    output logic [31:0]               mem_write_data,
    input  logic [31:0]               mem_read_data
);

    lsu_state_e                state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]                f3_q, f3_d;
    logic [31:0]               wdata_q, wdata_d;
    logic [31:0]               rdata_q, rdata_d;
    logic                      err_q, err_d;

    logic                      accept;
    logic                      out_of_win;
    logic                      req_err;
    logic [31:0]               ld_data;

    load_align_ext u_align (
        .word_i   (mem_read_data),
        .offset_i (addr_q[1:0]),
        .funct3_i (f3_q),
        .data_o   (ld_data)
    );

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    // Window compare only looks at bits above the memory's address range.
    assign out_of_win = req_addr[31:MEM_ADDR_WIDTH] != MEM_BASE[31:MEM_ADDR_WIDTH];
    assign req_err    = !f3_legal(req_write, req_funct3) ||
                        misaligned(req_funct3, req_addr[1:0]) ||
                        out_of_win;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = req_addr[MEM_ADDR_WIDTH-1:0];
                    f3_d    = req_funct3;
                    wdata_d = lane_rep(req_funct3, req_wdata);
                    rdata_d = 32'h0;
                    err_d   = req_err;
                    if (req_err) begin
                        state_d = RESP;
                    end else if (req_write) begin
                        state_d = STORE;
                    end else begin
                        state_d = LOAD_ADDR;
                    end
                end
            end
            STORE:     state_d = RESP;
            LOAD_ADDR: state_d = LOAD_DATA;
            LOAD_DATA: begin
                rdata_d = ld_data;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            f3_q    <= 3'b000;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Strobes come straight off the state register so reset kills them at once.
    assign mem_write      = (state_q == STORE);
    assign mem_byte_en    = mem_write ? byte_en(f3_q, addr_q[1:0]) : 4'b0000;
    assign mem_write_data = wdata_q;
    assign mem_write_addr = addr_q;
    assign mem_read_addr  = addr_q;

    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
